// File: rtl/vc_credit_arbiter.sv
// vc_credit_arbiter
// Drain side of a multi-lane input buffer. Each cycle it picks one lane
// round-robin from the lanes that are non-empty and have downstream credit.
// It pops that lane and registers the flit plus its lane tag toward the link.
// Per-lane credit counters decrement on send and increment on credit return.
// A return into a full counter saturates and raises a sticky error flag.
module vc_credit_arbiter #(
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 5,
  // A single-lane build still needs a 1-bit lane index to stay well formed.
  parameter int LANE_BITS  = (LANES > 1) ? $clog2(LANES) : 1,
  parameter int CRED_BITS  = $clog2(CREDITS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [LANES-1:0]               empty,
  input  logic [DATA_WIDTH-1:0]          fifo_dout,
  output logic                           pop,
  output logic [LANE_BITS-1:0]           pop_lane,
  input  logic [LANES-1:0]               credit_return,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [LANE_BITS-1:0]           out_lane,
  output logic [LANES*CRED_BITS-1:0]     credits,
  output logic                           credit_err
);

  localparam logic [CRED_BITS-1:0] CRED_FULL = CRED_BITS'(CREDITS);
  localparam logic [CRED_BITS-1:0] CRED_ONE  = CRED_BITS'(1);
  localparam logic [LANE_BITS-1:0] LANE_LAST = LANE_BITS'(LANES - 1);
  localparam logic [LANE_BITS-1:0] LANE_ONE  = LANE_BITS'(1);

  // Registered state
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [LANE_BITS-1:0]  out_lane_q,  out_lane_d;
  logic [LANE_BITS-1:0]  rr_ptr_q,    rr_ptr_d;
  logic                  credit_err_q, credit_err_d;
  logic [CRED_BITS-1:0]  credit_q [LANES];
  logic [CRED_BITS-1:0]  credit_d [LANES];

  // Combinational helpers
  logic [LANES-1:0]      elig_s;
  logic                  grant_found_s;
  logic [LANE_BITS-1:0]  grant_lane_s;
  logic [LANE_BITS-1:0]  scan_lane_s;
  logic                  pop_s;
  logic [LANES-1:0]      send_s;
  logic [LANES-1:0]      overflow_s;

  // A lane may be served only if it holds a flit and downstream has room for it.
  always_comb begin
    elig_s = '0;
    for (int l = 0; l < LANES; l++) begin
      elig_s[l] = ~empty[l] & (credit_q[l] != '0);
    end
  end

  // Round-robin scan starting at rr_ptr; the first eligible lane wins this cycle.
  always_comb begin
    grant_found_s = 1'b0;
    grant_lane_s  = '0;
    scan_lane_s   = '0;
    for (int i = 0; i < LANES; i++) begin
      scan_lane_s = LANE_BITS'((int'(rr_ptr_q) + i) % LANES);
      if (!grant_found_s && elig_s[scan_lane_s]) begin
        grant_found_s = 1'b1;
        grant_lane_s  = scan_lane_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Pop strobe and lane select go straight to the buffer (show-ahead read).
  always_comb begin
    pop_s = enable & grant_found_s & ~reset;
    if (reset || !grant_found_s) begin
      pop_lane = '0;
    end else begin
      pop_lane = grant_lane_s;
    end
    pop = pop_s;
  end

  // One-hot view of which lane is sending this edge.
  always_comb begin
    send_s = '0;
    for (int l = 0; l < LANES; l++) begin
      send_s[l] = pop_s & (grant_lane_s == LANE_BITS'(l));
    end
  end

  // Credit counters: net of send and return; a return into a full counter saturates.
  always_comb begin
    overflow_s = '0;
    for (int l = 0; l < LANES; l++) begin
      credit_d[l] = credit_q[l];
      case ({send_s[l], credit_return[l]})
        2'b10: credit_d[l] = credit_q[l] - CRED_ONE;
        2'b01: begin
          if (credit_q[l] == CRED_FULL) begin
            credit_d[l]   = credit_q[l];
            overflow_s[l] = 1'b1;
          end else begin
            credit_d[l] = credit_q[l] + CRED_ONE;
          end
        end
        default: credit_d[l] = credit_q[l];
      endcase
    end
    credit_err_d = credit_err_q | (|overflow_s);
  end

  // Output stage and round-robin pointer advance on a pop; the flit holds otherwise.
  always_comb begin
    out_valid_d = pop_s;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    rr_ptr_d    = rr_ptr_q;
    if (pop_s) begin
      out_data_d = fifo_dout;
      out_lane_d = grant_lane_s;
      if (grant_lane_s == LANE_LAST) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_lane_s + LANE_ONE;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers with synchronous reset; credits reload to full.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_lane_q   <= '0;
      rr_ptr_q     <= '0;
      credit_err_q <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        credit_q[l] <= CRED_FULL;
      end
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_lane_q   <= out_lane_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_err_q <= credit_err_d;
      for (int l = 0; l < LANES; l++) begin
        credit_q[l] <= credit_d[l];
      end
    end
  end

  // Flatten the credit counters onto the status port.
  always_comb begin
    credits = '0;
    for (int l = 0; l < LANES; l++) begin
      credits[l*CRED_BITS +: CRED_BITS] = credit_q[l];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_lane   = out_lane_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_vc_credit_arbiter.sv
// Directed bench for vc_credit_arbiter (LANES=2, DATA_WIDTH=32, CREDITS=5).
// A small two-lane show-ahead FIFO model feeds the arbiter.
module tb_vc_credit_arbiter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  empty;
  logic [31:0] fifo_dout;
  logic        pop;
  logic        pop_lane;
  logic [1:0]  credit_return;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_lane;
  logic [5:0]  credits;
  logic        credit_err;

  vc_credit_arbiter #(.LANES(2), .DATA_WIDTH(32), .CREDITS(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .empty(empty),
    .fifo_dout(fifo_dout), .pop(pop), .pop_lane(pop_lane),
    .credit_return(credit_return), .out_valid(out_valid),
    .out_data(out_data), .out_lane(out_lane), .credits(credits),
    .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO model
  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  int          rd0, wr0, rd1, wr1;

  assign empty     = {(rd1 == wr1), (rd0 == wr0)};
  assign fifo_dout = pop_lane ? mem1[rd1[3:0]] : mem0[rd0[3:0]];

  int   checks;
  int   errors;
  logic last_pop;
  logic last_lane;
  int   pop_count;

  typedef struct {
    logic        en;
    logic [1:0]  cr;
    logic        exp_pop;
    logic        exp_lane;
    logic        exp_ov;
    logic        exp_ol;
    logic [31:0] exp_od;
    logic [2:0]  exp_c0;
    logic [2:0]  exp_c1;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_fifo();
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
  endtask

  task automatic push(input int lane, input logic [31:0] d);
    if (lane == 0) begin
      mem0[wr0[3:0]] = d; wr0++;
    end else begin
      mem1[wr1[3:0]] = d; wr1++;
    end
  endtask

  // One clock: sample the combinational pop before the edge, retire it in the model after.
  task automatic tick();
    @(negedge clk);
    last_pop  = pop;
    last_lane = pop_lane;
    @(posedge clk);
    #1;
    if (last_pop) begin
      if (last_lane) rd1++;
      else rd0++;
    end
    credit_return = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_fifo();
  endtask

  initial begin
    checks = 0; errors = 0;
    enable = 1'b1; credit_return = 2'b00; reset = 1'b1;
    clear_fifo();
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 32'd0; mem1[i] = 32'd0;
    end

    // Interleave table: lane0 = 1,2,3 and lane1 = 4,5,6
    vecs[0] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 3'd4, 3'd5};
    vecs[1] = '{1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 3'd4, 3'd4};
    vecs[2] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 3'd3, 3'd4};
    vecs[3] = '{1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 32'd5, 3'd3, 3'd3};
    vecs[4] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 3'd2, 3'd3};
    vecs[5] = '{1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 32'd6, 3'd2, 3'd2};
    vecs[6] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd6, 3'd2, 3'd2};
    vecs[7] = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 32'd6, 3'd3, 3'd3};

    // Reset and idle
    tick();
    chk("pop_in_reset", {31'd0, last_pop}, 32'd0);
    do_reset();
    tick();
    chk("idle_pop", {31'd0, last_pop}, 32'd0);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_credits", {26'd0, credits}, {26'd0, 3'd5, 3'd5});
    chk("idle_credit_err", {31'd0, credit_err}, 32'd0);

    // Round-robin interleave, table-driven
    push(0, 32'd1); push(0, 32'd2); push(0, 32'd3);
    push(1, 32'd4); push(1, 32'd5); push(1, 32'd6);
    for (int v = 0; v < 8; v++) begin
      enable        = vecs[v].en;
      credit_return = vecs[v].cr;
      tick();
      chk($sformatf("v%0d_pop", v),       {31'd0, last_pop},   {31'd0, vecs[v].exp_pop});
      chk($sformatf("v%0d_pop_lane", v),  {31'd0, last_lane},  {31'd0, vecs[v].exp_lane});
      chk($sformatf("v%0d_out_valid", v), {31'd0, out_valid},  {31'd0, vecs[v].exp_ov});
      chk($sformatf("v%0d_out_lane", v),  {31'd0, out_lane},   {31'd0, vecs[v].exp_ol});
      chk($sformatf("v%0d_out_data", v),  out_data,            vecs[v].exp_od);
      chk($sformatf("v%0d_credit0", v),   {29'd0, credits[2:0]}, {29'd0, vecs[v].exp_c0});
      chk($sformatf("v%0d_credit1", v),   {29'd0, credits[5:3]}, {29'd0, vecs[v].exp_c1});
    end
    enable = 1'b1;

    // Credit exhaustion on lane 0 with 7 flits queued
    do_reset();
    for (int i = 0; i < 7; i++) push(0, 32'd10 + 32'(i));
    pop_count = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (last_pop) pop_count++;
    end
    chk("exhaust_pops", 32'(pop_count), 32'd5);
    chk("exhaust_credit0", {29'd0, credits[2:0]}, 32'd0);
    chk("exhaust_out_valid", {31'd0, out_valid}, 32'd0);
    credit_return = 2'b01;
    tick();
    chk("return_edge_no_pop", {31'd0, last_pop}, 32'd0);
    chk("return_credit0", {29'd0, credits[2:0]}, 32'd1);
    tick();
    chk("return_pop", {31'd0, last_pop}, 32'd1);
    chk("return_out_data", out_data, 32'd15);
    chk("return_out_valid", {31'd0, out_valid}, 32'd1);
    pop_count = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (last_pop) pop_count++;
    end
    chk("return_single_pop", 32'(pop_count), 32'd0);
    chk("return_credit0_end", {29'd0, credits[2:0]}, 32'd0);

    // Simultaneous send and return on lane 1 at credit 3
    do_reset();
    push(1, 32'd20); push(1, 32'd21); push(1, 32'd22);
    tick();
    tick();
    chk("simul_pre_credit1", {29'd0, credits[5:3]}, 32'd3);
    credit_return = 2'b10;
    tick();
    chk("simul_pop", {31'd0, last_pop}, 32'd1);
    chk("simul_lane", {31'd0, last_lane}, 32'd1);
    chk("simul_credit1", {29'd0, credits[5:3]}, 32'd3);
    chk("simul_out_data", out_data, 32'd22);
    chk("simul_no_err", {31'd0, credit_err}, 32'd0);

    // Return into a full counter
    credit_return = 2'b01;
    tick();
    chk("ovf_credit0", {29'd0, credits[2:0]}, 32'd5);
    chk("ovf_err", {31'd0, credit_err}, 32'd1);
    tick();
    tick();
    chk("ovf_err_sticky", {31'd0, credit_err}, 32'd1);

    // Reset in flight with rr_ptr pointing at lane 1
    do_reset();
    chk("reset_clears_err", {31'd0, credit_err}, 32'd0);
    push(0, 32'd30); push(0, 32'd31); push(0, 32'd32);
    push(1, 32'd40); push(1, 32'd41);
    tick(); tick(); tick();
    chk("flight_out_valid", {31'd0, out_valid}, 32'd1);
    chk("flight_credits", {26'd0, credits}, {26'd0, 3'd4, 3'd3});
    reset = 1'b1;
    tick();
    chk("flight_pop_in_reset", {31'd0, last_pop}, 32'd0);
    chk("flight_reset_ov", {31'd0, out_valid}, 32'd0);
    chk("flight_reset_credits", {26'd0, credits}, {26'd0, 3'd5, 3'd5});
    reset = 1'b0;
    tick();
    chk("post_reset_pop", {31'd0, last_pop}, 32'd1);
    chk("post_reset_lane", {31'd0, last_lane}, 32'd0);
    chk("post_reset_out_data", out_data, 32'd32);
    chk("post_reset_out_lane", {31'd0, out_lane}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
